// File: rtl/spi_rx_bytes.sv
// SPI mode-0 slave receive stage: synchronizes sck/sdi/cs into clk, assembles
// MSB-first bytes and queues them in a show-ahead FIFO with a valid/ready output.
module spi_rx_bytes #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs,
    output logic [7:0] byteOut,
    output logic       byteValid,
    input  logic       byteReady,
    output logic       frameDone,
    output logic       partialErr,
    output logic       overflow
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_STEP = (AW + 1)'(1);

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_sdi_meta, r_sdi_sync;
    logic r_cs_meta, r_cs_sync, r_cs_prev;

    logic [7:0] r_shift;
    logic [2:0] r_bit_count;

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic r_frame_done;
    logic r_partial_err;
    logic r_overflow;

    logic       w_sck_rise;
    logic       w_cs_fall;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic       w_wr_en;
    logic [7:0] w_byte;

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_sdi_meta <= 1'b0;
            r_sdi_sync <= 1'b0;
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_prev  <= 1'b0;
        end else begin
            r_sck_meta <= sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_sdi_meta <= sdi;
            r_sdi_sync <= r_sdi_meta;
            r_cs_meta  <= cs;
            r_cs_sync  <= r_cs_meta;
            r_cs_prev  <= r_cs_sync;
        end
    end

    assign w_sck_rise = r_sck_sync & ~r_sck_prev;
    assign w_cs_fall  = ~r_cs_sync & r_cs_prev;

    // A csFall always has csSync low, so it also masks any coincident sck edge.
    assign w_byte = {r_shift[6:0], r_sdi_sync};
    assign w_push = w_sck_rise & r_cs_sync & (r_bit_count == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= 8'h00;
            r_bit_count <= 3'd0;
        end else if (!r_cs_sync) begin
            r_shift     <= 8'h00;
            r_bit_count <= 3'd0;
        end else if (w_sck_rise) begin
            r_shift     <= w_byte;
            r_bit_count <= r_bit_count + 3'd1;
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & byteReady;
    assign w_wr_en = w_push & (~w_full | w_pop);

    // NOTE: the storage array has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_done  <= 1'b0;
            r_partial_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_done <= w_cs_fall;
            if (w_cs_fall && (r_bit_count != 3'd0)) begin
                r_partial_err <= 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head byte is forced to zero while empty so reset and idle read back 0x00.
    assign byteOut    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign byteValid  = ~w_empty;
    assign frameDone  = r_frame_done;
    assign partialErr = r_partial_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_rx_bytes.sv
// Scoreboard bench for spi_rx_bytes: stimulus queues expected bytes, a negedge
// monitor pops and compares every accepted byte; flags and timing checked inline.
module tb_spi_rx_bytes;
    logic       clk;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       cs;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       byteReady;
    logic       frameDone;
    logic       partialErr;
    logic       overflow;

    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         pops     = 0;
    int         fd_count = 0;

    spi_rx_bytes #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .sdi       (sdi),
        .cs        (cs),
        .byteOut   (byteOut),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .frameDone (frameDone),
        .partialErr(partialErr),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (frameDone) fd_count++;
        if (!reset && byteValid && byteReady) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got 0x%02h, expected no byte", byteOut);
            end else begin
                check("pop_data", {24'd0, byteOut}, {24'd0, sb.pop_front()});
                pops++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        sdi = b;
        tick(4);
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    // Last bit raises byteReady for exactly the clk edge that performs the push.
    task automatic spi_byte_pop(input logic [7:0] b);
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        sdi = b[0];
        tick(4);
        sck = 1'b1;
        tick(2);
        byteReady = 1'b1;
        tick(1);
        byteReady = 1'b0;
        tick(1);
        sck = 1'b0;
    endtask

    task automatic drain(input string name);
        byteReady = 1'b1;
        for (int i = 0; i < 20 && byteValid; i++) tick(1);
        check({name, "_drained"}, {31'd0, byteValid}, 32'd0);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        byteReady = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0;
        int p0;
        reset     = 1'b1;
        sck       = 1'b0;
        sdi       = 1'b0;
        cs        = 1'b0;
        byteReady = 1'b0;
        tick(3);
        check("rst_valid",   {31'd0, byteValid},  32'd0);
        check("rst_byteout", {24'd0, byteOut},    32'd0);
        check("rst_fdone",   {31'd0, frameDone},  32'd0);
        check("rst_partial", {31'd0, partialErr}, 32'd0);
        check("rst_ovf",     {31'd0, overflow},   32'd0);
        reset = 1'b0;
        tick(2);

        // Single byte, byteReady low.
        cs = 1'b1;
        tick(4);
        sb.push_back(8'hA5);
        fd0 = fd_count;
        spi_byte(8'hA5);
        check("single_valid", {31'd0, byteValid}, 32'd1);
        check("single_head",  {24'd0, byteOut},   32'hA5);
        cs = 1'b0;
        tick(8);
        check("single_fdone_once", fd_count - fd0, 32'd1);
        check("single_partial", {31'd0, partialErr}, 32'd0);
        check("single_ovf",     {31'd0, overflow},   32'd0);
        drain("single");

        // Back-pressure: three bytes, then one pop per cycle.
        cs = 1'b1;
        tick(4);
        sb.push_back(8'h12); spi_byte(8'h12);
        sb.push_back(8'h34); spi_byte(8'h34);
        sb.push_back(8'h56); spi_byte(8'h56);
        cs = 1'b0;
        tick(8);
        check("bp_valid_held", {31'd0, byteValid}, 32'd1);
        p0 = pops;
        byteReady = 1'b1;
        tick(3);
        check("bp_three_pops", pops - p0, 32'd3);
        check("bp_empty_after", {31'd0, byteValid}, 32'd0);
        byteReady = 1'b0;
        tick(1);

        // Overflow: fifth byte dropped.
        cs = 1'b1;
        tick(4);
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) sb.push_back(8'(b));
            spi_byte(8'(b));
        end
        cs = 1'b0;
        tick(8);
        check("ovf_set",  {31'd0, overflow},  32'd1);
        check("ovf_head", {24'd0, byteOut},   32'h01);
        drain("ovf");
        do_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with a pop coinciding with the fifth push.
        cs = 1'b1;
        tick(4);
        for (int b = 1; b <= 5; b++) sb.push_back(8'(b));
        for (int b = 1; b <= 4; b++) spi_byte(8'(b));
        spi_byte_pop(8'h05);
        cs = 1'b0;
        tick(8);
        check("ovf_pop_flag", {31'd0, overflow}, 32'd0);
        check("ovf_pop_head", {24'd0, byteOut},  32'h02);
        drain("ovf_pop");

        // Partial byte: 0xFF then 5 stray bits.
        cs = 1'b1;
        tick(4);
        sb.push_back(8'hFF);
        spi_byte(8'hFF);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        cs = 1'b0;
        tick(8);
        check("partial_set", {31'd0, partialErr}, 32'd1);
        drain("partial");
        cs = 1'b1;
        tick(4);
        sb.push_back(8'h3C);
        spi_byte(8'h3C);
        cs = 1'b0;
        tick(8);
        check("partial_sticky", {31'd0, partialErr}, 32'd1);
        drain("after_partial");

        // sck pulses with cs low are ignored.
        do_reset();
        fd0 = fd_count;
        spi_byte(8'hFF);
        tick(8);
        check("ign_valid",   {31'd0, byteValid},  32'd0);
        check("ign_fdone",   fd_count - fd0,      32'd0);
        check("ign_partial", {31'd0, partialErr}, 32'd0);
        check("ign_ovf",     {31'd0, overflow},   32'd0);

        // Asynchronous reset mid-byte with two bytes queued.
        cs = 1'b1;
        tick(4);
        spi_byte(8'h11);
        spi_byte(8'h22);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0);
        check("pre_rst_valid", {31'd0, byteValid}, 32'd1);
        reset = 1'b1;
        #2;
        check("async_rst_valid",   {31'd0, byteValid},  32'd0);
        check("async_rst_byteout", {24'd0, byteOut},    32'd0);
        check("async_rst_fdone",   {31'd0, frameDone},  32'd0);
        check("async_rst_partial", {31'd0, partialErr}, 32'd0);
        check("async_rst_ovf",     {31'd0, overflow},   32'd0);
        sck = 1'b0;
        sdi = 1'b0;
        cs  = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        cs = 1'b1;
        tick(4);
        sb.push_back(8'h81);
        spi_byte(8'h81);
        cs = 1'b0;
        tick(8);
        check("post_rst_head",    {24'd0, byteOut},    32'h81);
        check("post_rst_partial", {31'd0, partialErr}, 32'd0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
